nes_controller_responder: RTL and testbench

Emulates the controller end of the NES serial pad protocol: it samples an 8-bit button vector on `nesLatch` and shifts it out on `nesData` on rising edges of `nesClock`, behaving like a CD4021 shift register. It is the counterpart of the host-side NES interface that feeds the Capman CPU. It is used on a second board or in simulation to drive scripted input into the game without a physical pad.

---
 rtl/nes_pkg.sv | 13 +
 rtl/nes_input_sync.sv | 28 ++
 rtl/nes_controller_responder.sv | 93 +++++++++
 tb/tb_nes_controller_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// nes_pkg: shared state encoding, button indices and frame width for the NES pad responder
package nes_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFTING, DONE} nes_state_t;
  localparam int NES_BITS  = 8;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
endpackage

// File: rtl/nes_input_sync.sv
// nes_input_sync: multi-stage synchronizer with rise/fall pulse detection
//   clk, reset (async active-low), d (asynchronous pin)
//   q (synchronized level), rise/fall (one-cycle pulses on q edges)
module nes_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/nes_controller_responder.sv
// nes_controller_responder: CD4021-style NES pad emulation driven by a button vector
//   clk, reset (async active-low), nesLatch/nesClock (async host pins), buttons (active-high)
//   nesData (active-low serial), frameDone/frameAbort (pulses), frameCount, busy
module nes_controller_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nesLatch,
  input  logic                nesClock,
  input  logic [NES_BITS-1:0] buttons,
  output logic                nesData,
  output logic                frameDone,
  output logic                frameAbort,
  output logic [7:0]          frameCount,
  output logic                busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  nes_state_t state, state_d;
  logic latch_s, latch_rise, latch_fall;
  logic clk_s_unused, clk_rise, clk_fall_unused;
  logic [NES_BITS-1:0] sr;
  logic [2:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic do_shift, done_d, abort_d, timed_out;
  nes_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
    .clk(clk), .reset(reset), .d(nesLatch),
    .q(latch_s), .rise(latch_rise), .fall(latch_fall)
  );
  nes_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clock (
    .clk(clk), .reset(reset), .d(nesClock),
    .q(clk_s_unused), .rise(clk_rise), .fall(clk_fall_unused)
  );
  assign timed_out = to_cnt == TW'(TIMEOUT_CYCLES);
  assign busy      = (state == LOAD) || (state == SHIFTING);
  // A latch rise outranks a simultaneous clock rise, so the clock edge is dropped.
  always_comb begin
    state_d  = state;
    do_shift = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state)
      IDLE:    state_d = latch_s ? LOAD : IDLE;
      LOAD:    state_d = latch_fall ? SHIFTING : LOAD;
      SHIFTING: begin
        if (latch_rise) begin
          state_d = LOAD;
          abort_d = 1'b1;
        end else if (clk_rise) begin
          do_shift = 1'b1;
          done_d   = bit_cnt == 3'd7;
          state_d  = done_d ? DONE : SHIFTING;
        end else if (timed_out) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      default: state_d = latch_rise ? LOAD : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sr         <= '1;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      nesData    <= 1'b1;
      frameDone  <= 1'b0;
      frameAbort <= 1'b0;
      frameCount <= '0;
    end else begin
      state      <= state_d;
      frameDone  <= done_d;
      frameAbort <= abort_d;
      frameCount <= frameCount + {7'b0, done_d};
      to_cnt     <= (state != SHIFTING || clk_rise) ? '0 : timed_out ? to_cnt : to_cnt + 1'b1;
      if (state == LOAD) begin
        sr      <= ~buttons;
        bit_cnt <= '0;
        nesData <= ~buttons[BTN_A];
      end else if (do_shift) begin
        sr      <= {1'b0, sr[NES_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
        nesData <= done_d ? 1'b0 : sr[1];
      end else if (state == DONE) begin
        nesData <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nes_controller_responder.sv
// tb_nes_controller_responder: directed checks of frame shifting, aborts, timeout, wrap and reset
module tb_nes_controller_responder;
  localparam int TO = 300;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic nesLatch = 1'b0;
  logic nesClock = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic nesData, frameDone, frameAbort, busy;
  logic [7:0] frameCount;
  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_abort = 0;
  int n_both = 0;
  logic [7:0] exp_cnt = 8'h00;
  nes_controller_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .nesLatch(nesLatch), .nesClock(nesClock),
    .buttons(buttons), .nesData(nesData), .frameDone(frameDone),
    .frameAbort(frameAbort), .frameCount(frameCount), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frameDone) n_done++;
    if (frameAbort) n_abort++;
    if (frameDone && frameAbort) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse();
    nesClock = 1'b1;
    tick(5);
    nesClock = 1'b0;
    tick(5);
  endtask
  task automatic load(input logic [7:0] b);
    logic e;
    e = ~b[0];
    buttons = b;
    nesLatch = 1'b1;
    tick(8);
    chk("load_data", 32'(nesData), 32'(e));
    chk("load_busy", 32'(busy), 32'd1);
    nesLatch = 1'b0;
    tick(6);
    chk("shift_bit0", 32'(nesData), 32'(e));
  endtask
  task automatic shift_bits(input logic [7:0] b, input int n);
    logic e;
    for (int i = 1; i <= n; i++) begin
      pulse();
      e = (i < 8) ? ~b[i % 8] : 1'b0;
      chk("shift_bit", 32'(nesData), 32'(e));
    end
  endtask
  task automatic finish_frame(input logic [7:0] b, input int d0);
    shift_bits(b, 8);
    exp_cnt = exp_cnt + 8'd1;
    chk("done_pulse", n_done, d0 + 1);
    chk("frame_count", 32'(frameCount), 32'(exp_cnt));
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask
  task automatic frame(input logic [7:0] b);
    int d0;
    d0 = n_done;
    load(b);
    finish_frame(b, d0);
  endtask
  initial begin
    int d0, a0;
    tick(3);
    chk("rst_data", 32'(nesData), 32'd1);
    chk("rst_done", 32'(frameDone), 32'd0);
    chk("rst_abort", 32'(frameAbort), 32'd0);
    chk("rst_count", 32'(frameCount), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick(3);
    // full frame: A and Start pressed -> 0,1,1,0,1,1,1,1 then 0
    frame(8'b0000_1001);
    // clock pulses while idle after a frame must not disturb anything
    d0 = n_done;
    pulse();
    chk("idle_clock_done", n_done, d0);
    chk("done_data_low", 32'(nesData), 32'd0);
    // live reload while latch is held
    d0 = n_done;
    buttons = 8'h00;
    nesLatch = 1'b1;
    tick(8);
    chk("reload_before", 32'(nesData), 32'd1);
    buttons = 8'h01;
    tick(4);
    chk("reload_after", 32'(nesData), 32'd0);
    nesLatch = 1'b0;
    tick(6);
    finish_frame(8'h01, d0);
    // re-latch mid-frame
    d0 = n_done;
    a0 = n_abort;
    load(8'h09);
    shift_bits(8'h09, 3);
    load(8'h02);
    chk("relatch_abort", n_abort, a0 + 1);
    chk("relatch_no_done", n_done, d0);
    chk("relatch_count", 32'(frameCount), 32'(exp_cnt));
    finish_frame(8'h02, d0);
    // timeout
    a0 = n_abort;
    load(8'h55);
    shift_bits(8'h55, 2);
    tick(200);
    chk("timeout_wait_busy", 32'(busy), 32'd1);
    chk("timeout_wait_abort", n_abort, a0);
    tick(150);
    chk("timeout_abort", n_abort, a0 + 1);
    chk("timeout_busy", 32'(busy), 32'd0);
    frame(8'hA5);
    // collision: latch and clock rise together while shifting
    d0 = n_done;
    a0 = n_abort;
    load(8'h09);
    shift_bits(8'h09, 2);
    buttons = 8'h81;
    nesLatch = 1'b1;
    nesClock = 1'b1;
    tick(8);
    chk("collide_abort", n_abort, a0 + 1);
    chk("collide_busy", 32'(busy), 32'd1);
    chk("collide_data", 32'(nesData), 32'd0);
    nesClock = 1'b0;
    tick(2);
    nesLatch = 1'b0;
    tick(6);
    chk("collide_bit0", 32'(nesData), 32'd0);
    finish_frame(8'h81, d0);
    // reset mid-shift: bit 4 pressed so nesData is low before reset
    load(8'h10);
    shift_bits(8'h10, 4);
    chk("pre_reset_data", 32'(nesData), 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_data", 32'(nesData), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(frameCount), 32'd0);
    exp_cnt = 8'h00;
    nesLatch = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("post_reset_busy", 32'(busy), 32'd0);
    frame(8'h3C);
    // wrap: 255 more frames bring the count back to 0
    for (int f = 0; f < 255; f++) frame(8'(f));
    chk("wrap_count", 32'(frameCount), 32'd0);
    chk("never_both", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
